// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline encodings for the 5-stage MIPS core: MemToReg/RegDst codes,
// destination-register decode and the hazard controller state type.
package cpu_pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned MTR_W = 2;
  localparam int unsigned RDST_W = 2;

  localparam logic [MTR_W-1:0] MTR_ALU = 2'd0;
  localparam logic [MTR_W-1:0] MTR_MEM = 2'd1;
  localparam logic [MTR_W-1:0] MTR_PC4 = 2'd2;

  localparam logic [RDST_W-1:0] RDST_RD = 2'd0;
  localparam logic [RDST_W-1:0] RDST_RT = 2'd1;
  localparam logic [RDST_W-1:0] RDST_RA = 2'd2;
  localparam logic [RDST_W-1:0] RDST_XC = 2'd3;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;
  localparam logic [REG_W-1:0] REG_XC = 5'd26;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

  // Architectural register written by a producer, from its RegDst select.
  function automatic logic [REG_W-1:0] dest_reg(input logic [RDST_W-1:0] reg_dst,
                                                input logic [REG_W-1:0]  rd,
                                                input logic [REG_W-1:0]  rt);
    logic [REG_W-1:0] d;
    case (reg_dst)
      RDST_RD: d = rd;
      RDST_RT: d = rt;
      RDST_RA: d = REG_RA;
      default: d = REG_XC;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight producer's destination against the ID-stage sources.
module hazard_match
  import cpu_pipe_pkg::*;
(
  input  logic              reg_wr_i,
  input  logic [RDST_W-1:0] reg_dst_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  input  logic              uses_rs_i,
  input  logic              uses_rt_i,
  output logic              hit_o
);

  logic [REG_W-1:0] dest;
  logic             wr_live;
  logic             hit_rs;
  logic             hit_rt;

  // $0 is never a real dependency, so a zero destination cannot match.
  assign dest    = dest_reg(reg_dst_i, rd_i, rt_i);
  assign wr_live = reg_wr_i && (dest != '0);
  assign hit_rs  = wr_live && uses_rs_i && (dest == id_rs_i);
  assign hit_rt  = wr_live && uses_rt_i && (dest == id_rt_i);
  assign hit_o   = hit_rs || hit_rt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / ID-branch hazard stall FSM plus PC, IF/ID and ID/EX control.
// Optional HAZARD_STATS_EN adds saturating event counters.
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 2
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned STAT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic              ID_IsBranch,
  input  logic              ID_Jump,
  input  logic              ID_BranchTaken,
  input  logic              EX_RegWr,
  input  logic [MTR_W-1:0]  EX_MemToReg,
  input  logic [RDST_W-1:0] EX_RegDst,
  input  logic [REG_W-1:0]  EX_Rd,
  input  logic [REG_W-1:0]  EX_Rt,
  input  logic              MEM_RegWr,
  input  logic [MTR_W-1:0]  MEM_MemToReg,
  input  logic [RDST_W-1:0] MEM_RegDst,
  input  logic [REG_W-1:0]  MEM_Rd,
  input  logic [REG_W-1:0]  MEM_Rt,
  output logic              PC_Wr,
  output logic              IF_ID_Wr,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
`ifdef HAZARD_STATS_EN
  output logic [STAT_W-1:0] Stat_LoadUse,
  output logic [STAT_W-1:0] Stat_BranchStall,
  output logic [STAT_W-1:0] Stat_Flush,
`endif
  output logic              Stalling
);

  stall_state_e           state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] need;
  logic                   ex_hit;
  logic                   mem_hit;
  logic                   stall_c;

  hazard_match u_ex_match (
    .reg_wr_i  (EX_RegWr),
    .reg_dst_i (EX_RegDst),
    .rd_i      (EX_Rd),
    .rt_i      (EX_Rt),
    .id_rs_i   (ID_Rs),
    .id_rt_i   (ID_Rt),
    .uses_rs_i (ID_UsesRs),
    .uses_rt_i (ID_UsesRt),
    .hit_o     (ex_hit)
  );

  hazard_match u_mem_match (
    .reg_wr_i  (MEM_RegWr),
    .reg_dst_i (MEM_RegDst),
    .rd_i      (MEM_Rd),
    .rt_i      (MEM_Rt),
    .id_rs_i   (ID_Rs),
    .id_rt_i   (ID_Rt),
    .uses_rs_i (ID_UsesRs),
    .uses_rt_i (ID_UsesRt),
    .hit_o     (mem_hit)
  );

  // Stall depth: the deepest applicable rule wins; PC+4 producers always forward.
  always_comb begin
    need = '0;
    if (ID_IsBranch) begin
      if (ex_hit && (EX_MemToReg == MTR_MEM)) begin
        need = STALL_CNT_W'(2);
      end else if ((ex_hit && (EX_MemToReg == MTR_ALU)) ||
                   (mem_hit && (MEM_MemToReg == MTR_MEM))) begin
        need = STALL_CNT_W'(1);
      end
    end else if (ex_hit && (EX_MemToReg == MTR_MEM)) begin
      need = STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and control outputs; reset low forces the defaults at once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    PC_Wr       = 1'b1;
    IF_ID_Wr    = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (need != '0) begin
            stall_c = 1'b1;
            cnt_d   = need - STALL_CNT_W'(1);
            if (cnt_d != '0) state_d = ST_STALL;
          end else if (ID_Jump || ID_BranchTaken) begin
            IF_ID_Flush = 1'b1;
          end
        end
        default: begin
          stall_c = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - STALL_CNT_W'(1);
          if (cnt_q <= STALL_CNT_W'(1)) state_d = ST_RUN;
        end
      endcase
      if (stall_c) begin
        PC_Wr       = 1'b0;
        IF_ID_Wr    = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  assign Stalling = (state_q == ST_STALL);

`ifdef HAZARD_STATS_EN
  logic br_cause_q;
  logic br_cause;

  // Remember which rule opened the stall so later STALL cycles are attributed to it.
  assign br_cause = (state_q == ST_RUN) ? ID_IsBranch : br_cause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cause_q       <= 1'b0;
      Stat_LoadUse     <= '0;
      Stat_BranchStall <= '0;
      Stat_Flush       <= '0;
    end else begin
      if (stall_c && (state_q == ST_RUN)) br_cause_q <= ID_IsBranch;
      if (stall_c && !br_cause && (Stat_LoadUse != '1))
        Stat_LoadUse <= Stat_LoadUse + STAT_W'(1);
      if (stall_c && br_cause && (Stat_BranchStall != '1))
        Stat_BranchStall <= Stat_BranchStall + STAT_W'(1);
      if (IF_ID_Flush && (Stat_Flush != '1))
        Stat_Flush <= Stat_Flush + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expected control vectors are hand-derived.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt, id_is_br, id_jump, id_taken;
  logic       ex_wr, mem_wr;
  logic [1:0] ex_mtr, ex_dst, mem_mtr, mem_dst;
  logic [4:0] ex_rd, ex_rt, mem_rd, mem_rt;
  logic       pc_wr, ifid_wr, ifid_flush, idex_flush, stalling;
`ifdef HAZARD_STATS_EN
  logic [31:0] st_lu, st_br, st_fl;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, Stalling}
  localparam logic [4:0] C_DEF   = 5'b11000;
  localparam logic [4:0] C_FLUSH = 5'b11100;
  localparam logic [4:0] C_STRUN = 5'b00010;
  localparam logic [4:0] C_STALL = 5'b00011;

  hazard_stall_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_Rs          (id_rs),
    .ID_Rt          (id_rt),
    .ID_UsesRs      (id_uses_rs),
    .ID_UsesRt      (id_uses_rt),
    .ID_IsBranch    (id_is_br),
    .ID_Jump        (id_jump),
    .ID_BranchTaken (id_taken),
    .EX_RegWr       (ex_wr),
    .EX_MemToReg    (ex_mtr),
    .EX_RegDst      (ex_dst),
    .EX_Rd          (ex_rd),
    .EX_Rt          (ex_rt),
    .MEM_RegWr      (mem_wr),
    .MEM_MemToReg   (mem_mtr),
    .MEM_RegDst     (mem_dst),
    .MEM_Rd         (mem_rd),
    .MEM_Rt         (mem_rt),
    .PC_Wr          (pc_wr),
    .IF_ID_Wr       (ifid_wr),
    .IF_ID_Flush    (ifid_flush),
    .ID_EX_Flush    (idex_flush),
`ifdef HAZARD_STATS_EN
    .Stat_LoadUse     (st_lu),
    .Stat_BranchStall (st_br),
    .Stat_Flush       (st_fl),
`endif
    .Stalling       (stalling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctrl(input string tag, input logic [4:0] exp);
    #1;
    check_eq(tag, 32'({pc_wr, ifid_wr, ifid_flush, idex_flush, stalling}), 32'(exp));
  endtask

  task automatic set_ex(input logic wr, input logic [1:0] mtr, input logic [1:0] dst,
                        input logic [4:0] rd, input logic [4:0] rt);
    ex_wr = wr; ex_mtr = mtr; ex_dst = dst; ex_rd = rd; ex_rt = rt;
  endtask

  task automatic set_mem(input logic wr, input logic [1:0] mtr, input logic [1:0] dst,
                         input logic [4:0] rd, input logic [4:0] rt);
    mem_wr = wr; mem_mtr = mtr; mem_dst = dst; mem_rd = rd; mem_rt = rt;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic br, input logic jmp, input logic tk);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_br = br; id_jump = jmp; id_taken = tk;
  endtask

  task automatic clear_all();
    set_ex(0, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_all();
    expect_ctrl("reset_default", C_DEF);
    step();
    rst_n = 1'b1;
    step();
    expect_ctrl("idle_default", C_DEF);

    // lw $8 in EX, add reads $8: one load-use bubble
    set_ex(1, 2'd1, 2'd1, 5'd0, 5'd8);
    set_id(5'd8, 5'd2, 1, 1, 0, 0, 0);
    expect_ctrl("loaduse_stall", C_STRUN);
    step();
    set_ex(0, 0, 0, 0, 0);
    set_mem(1, 2'd1, 2'd1, 5'd0, 5'd8);
    expect_ctrl("loaduse_release", C_DEF);
    step(); clear_all();

    // lw $9 in EX, beq reads Rt=9: two stall cycles
    set_ex(1, 2'd1, 2'd1, 5'd0, 5'd9);
    set_id(5'd3, 5'd9, 1, 1, 1, 0, 0);
    expect_ctrl("lw_beq_c0", C_STRUN);
    step();
    set_ex(0, 0, 0, 0, 0);
    set_mem(1, 2'd1, 2'd1, 5'd0, 5'd9);
    expect_ctrl("lw_beq_c1", C_STALL);
    step();
    set_mem(0, 0, 0, 0, 0);
    expect_ctrl("lw_beq_release", C_DEF);
    step(); clear_all();

    // add $5 in EX, bne reads $5: one stall, then MEM ALU result forwards
    set_ex(1, 2'd0, 2'd0, 5'd5, 5'd7);
    set_id(5'd5, 5'd0, 1, 0, 1, 0, 0);
    expect_ctrl("alu_bne_stall", C_STRUN);
    step();
    set_ex(0, 0, 0, 0, 0);
    set_mem(1, 2'd0, 2'd0, 5'd5, 5'd7);
    expect_ctrl("alu_bne_release", C_DEF);
    step(); clear_all();

    // jal in EX and MEM, jr $31 in ID: never stalls, jump flushes
    set_ex(1, 2'd2, 2'd2, 5'd0, 5'd0);
    set_mem(1, 2'd2, 2'd2, 5'd0, 5'd0);
    set_id(5'd31, 5'd0, 1, 0, 1, 1, 0);
    expect_ctrl("jal_jr_flush", C_FLUSH);
    step(); clear_all();
    expect_ctrl("jal_jr_after", C_DEF);

    // lw $0 with consumer of $0: no stall
    set_ex(1, 2'd1, 2'd1, 5'd0, 5'd0);
    set_id(5'd0, 5'd0, 1, 1, 0, 0, 0);
    expect_ctrl("dest_zero", C_DEF);
    // matching Rt that is not read: no stall
    set_ex(1, 2'd1, 2'd1, 5'd0, 5'd12);
    set_id(5'd1, 5'd12, 1, 0, 0, 0, 0);
    expect_ctrl("rt_unused", C_DEF);
    // RegDst=3 targets $26
    set_ex(1, 2'd1, 2'd3, 5'd0, 5'd0);
    set_id(5'd26, 5'd0, 1, 0, 0, 0, 0);
    expect_ctrl("dst_k0_stall", C_STRUN);
    step(); clear_all();
    expect_ctrl("dst_k0_release", C_DEF);

    // lw in MEM: branch stalls one cycle, ALU consumer does not
    set_mem(1, 2'd1, 2'd1, 5'd0, 5'd6);
    set_id(5'd0, 5'd6, 0, 1, 0, 0, 0);
    expect_ctrl("mem_lw_alu", C_DEF);
    id_is_br = 1'b1;
    expect_ctrl("mem_lw_br", C_STRUN);
    step(); clear_all();
    expect_ctrl("mem_lw_br_rel", C_DEF);

    // EX ALU and MEM load both hit a branch: max(1,1)=1, not a sum
    set_ex(1, 2'd0, 2'd0, 5'd4, 5'd0);
    set_mem(1, 2'd1, 2'd1, 5'd0, 5'd6);
    set_id(5'd4, 5'd6, 1, 1, 1, 0, 0);
    expect_ctrl("max_rule", C_STRUN);
    step(); clear_all();
    expect_ctrl("max_rule_rel", C_DEF);

    // taken branch with no hazard
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 1);
    expect_ctrl("taken_flush", C_FLUSH);
    step(); clear_all();
    expect_ctrl("taken_after", C_DEF);

    // taken asserted throughout a 2-cycle stall: flush only after release
    set_ex(1, 2'd1, 2'd1, 5'd0, 5'd9);
    set_id(5'd3, 5'd9, 1, 1, 1, 0, 1);
    expect_ctrl("taken_stall_c0", C_STRUN);
    step();
    set_ex(0, 0, 0, 0, 0);
    expect_ctrl("taken_stall_c1", C_STALL);
    step();
    expect_ctrl("taken_release", C_FLUSH);
    step(); clear_all();

    // reset abandons a branch stall
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    set_ex(1, 2'd1, 2'd1, 5'd0, 5'd9);
    set_id(5'd3, 5'd9, 1, 1, 1, 0, 0);
    expect_ctrl("rst_stall_c0", C_STRUN);
    step();
    expect_ctrl("rst_stall_c1", C_STALL);
`ifdef HAZARD_STATS_EN
    check_eq("stat_br_before", st_br, 32'd1);
`endif
    rst_n = 1'b0;
    expect_ctrl("rst_async_default", C_DEF);
`ifdef HAZARD_STATS_EN
    check_eq("stat_br_after", st_br, 32'd0);
`endif
    step();
    expect_ctrl("rst_held_hazard", C_DEF);
    rst_n = 1'b1;
    clear_all();
    step();
    expect_ctrl("rst_run_after", C_DEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
